// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol type, control tokens, stage-1 payload and
// an 8-bit popcount helper.
package tmds_pkg;

  localparam int unsigned SYM_W  = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned QM_W   = 9;
  localparam int unsigned CNT_W  = 5;

  typedef logic [SYM_W-1:0] sym_t;

  localparam sym_t CTRL_00 = 10'b1101010100;
  localparam sym_t CTRL_01 = 10'b0010101011;
  localparam sym_t CTRL_10 = 10'b0101010100;
  localparam sym_t CTRL_11 = 10'b1010101011;

  // Stage-1 pipeline payload: transition-minimised word plus sideband.
  typedef struct packed {
    logic [QM_W-1:0] q_m;
    logic            de;
    logic [1:0]      c;
  } stage1_t;

  function automatic logic [3:0] popcount8(input logic [DATA_W-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_encoder.sv
// TMDS 8b/10b encoder (DVI/HDMI channel encoder).
// Stage 1 minimises transitions (q_m); stage 2 balances DC using a running
// disparity count and emits control tokens during blanking.
// Ports:
//   clk  - pixel clock
//   rst  - asynchronous active-high reset
//   de   - data enable (1 = video data, 0 = control period)
//   d    - 8-bit pixel component
//   c    - control bits {c1,c0}
//   q    - 10-bit TMDS symbol, LSB first on the wire
// Build option: define TMDS_ENCODER_OUT_REG_EN to add an output register
// after the stage-2 register (latency 3 instead of 2).
module tmds_encoder
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       de,
  input  logic [7:0] d,
  input  logic [1:0] c,
  output logic [9:0] q
);

  logic                    use_xnor_c;
  logic [QM_W-1:0]         q_m_c;
  stage1_t                 s1;

  logic [3:0]              n1q_c;
  logic [3:0]              n0q_c;
  logic signed [CNT_W-1:0] diff_c;
  logic signed [CNT_W-1:0] cnt;
  logic signed [CNT_W-1:0] cnt_nxt_c;
  sym_t                    sym_nxt_c;
  sym_t                    q_s2;

  // Stage 1: choose XOR/XNOR chaining to minimise transitions.
  always_comb begin
    logic [3:0]      n1d;
    logic [QM_W-1:0] qm;
    n1d        = popcount8(d);
    use_xnor_c = (n1d > 4'd4) || ((n1d == 4'd4) && (d[0] == 1'b0));
    qm         = '0;
    qm[0]      = d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = use_xnor_c ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    end
    qm[8] = ~use_xnor_c;
    q_m_c = qm;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
    end else begin
      s1.q_m <= q_m_c;
      s1.de  <= de;
      s1.c   <= c;
    end
  end

  // Stage 2: DC balance against running disparity, or control token.
  always_comb begin
    n1q_c     = popcount8(s1.q_m[7:0]);
    n0q_c     = 4'd8 - n1q_c;
    diff_c    = $signed(5'(n1q_c)) - $signed(5'(n0q_c));
    sym_nxt_c = CTRL_00;
    cnt_nxt_c = cnt;
    if (!s1.de) begin
      // Control periods restart disparity so the next data symbol starts at 0.
      cnt_nxt_c = '0;
      case (s1.c)
        2'b00:   sym_nxt_c = CTRL_00;
        2'b01:   sym_nxt_c = CTRL_01;
        2'b10:   sym_nxt_c = CTRL_10;
        default: sym_nxt_c = CTRL_11;
      endcase
    end else if ((cnt == 5'sd0) || (n1q_c == n0q_c)) begin
      sym_nxt_c = {~s1.q_m[8], s1.q_m[8],
                   s1.q_m[8] ? s1.q_m[7:0] : ~s1.q_m[7:0]};
      cnt_nxt_c = s1.q_m[8] ? (cnt + diff_c) : (cnt - diff_c);
    end else if (((cnt > 5'sd0) && (n1q_c > n0q_c)) ||
                 ((cnt < 5'sd0) && (n0q_c > n1q_c))) begin
      sym_nxt_c = {1'b1, s1.q_m[8], ~s1.q_m[7:0]};
      cnt_nxt_c = cnt + (s1.q_m[8] ? 5'sd2 : 5'sd0) - diff_c;
    end else begin
      sym_nxt_c = {1'b0, s1.q_m[8], s1.q_m[7:0]};
      cnt_nxt_c = cnt + diff_c - (s1.q_m[8] ? 5'sd0 : 5'sd2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      q_s2 <= CTRL_00;
    end else begin
      cnt  <= cnt_nxt_c;
      q_s2 <= sym_nxt_c;
    end
  end

`ifdef TMDS_ENCODER_OUT_REG_EN
  sym_t q_out;

  // Extra retiming register toward the serializer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_out <= CTRL_00;
    end else begin
      q_out <= q_s2;
    end
  end

  assign q = q_out;
`else
  assign q = q_s2;
`endif

endmodule

// File: doc/tmds_encoder.md
TMDS_ENCODER -- requirements
Module: tmds_encoder

Interface
REQ-001 SHALL have no parameters; the only configuration is the macro in REQ-020.
REQ-002 SHALL have port clk, input, 1 bit: pixel clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous assert, active-high; design uses this one clock and this one reset only.
REQ-004 SHALL have port de, input, 1 bit: data enable; 1 = video data, 0 = control period.
REQ-005 SHALL have port d, input, 8 bits: pixel component, sampled when de=1.
REQ-006 SHALL have port c, input, 2 bits: control bits {c1,c0}, sampled when de=0.
REQ-007 SHALL have port q, output, 10 bits: TMDS symbol, LSB transmitted first by the downstream serializer and differential output buffer.

Function
REQ-008 SHALL run as a two-register pipeline: stage 1 registers q_m[8:0], de and c; stage 2 registers q. Latency from input to q is 2 cycles, throughput 1 symbol/cycle.
REQ-009 Stage 1 SHALL compute n1d = popcount(d) and select XNOR mode when n1d>4, or when n1d==4 and d[0]==0; otherwise select XOR mode.
REQ-010 Stage 1 SHALL form q_m[0]=d[0] and q_m[i]=q_m[i-1] XOR/XNOR d[i] for i=1..7, with q_m[8]=1 for XOR mode and 0 for XNOR mode.
REQ-011 Stage 2 SHALL keep running disparity cnt as a 5-bit two's-complement register; n1q/n0q are the ones/zeros counts of q_m[7:0].
REQ-012 When de=1 and (cnt==0 or n1q==n0q), stage 2 SHALL output q={~q_m[8], q_m[8], q_m[8]?q_m[7:0]:~q_m[7:0]}. It SHALL update cnt+=(n1q-n0q) if q_m[8]=1, else cnt+=(n0q-n1q).
REQ-013 When de=1 and ((cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q)), stage 2 SHALL output q={1, q_m[8], ~q_m[7:0]} and update cnt+=2*q_m[8]+(n0q-n1q).
REQ-014 When de=1 and neither REQ-012 nor REQ-013 applies, stage 2 SHALL output q={0, q_m[8], q_m[7:0]} and update cnt+=(n1q-n0q)-2*(~q_m[8]).
REQ-015 When de=0, stage 2 SHALL output the control token for the registered c and clear cnt to 0 in the same cycle. Tokens: 00->10'b1101010100, 01->10'b0010101011, 10->10'b0101010100, 11->10'b1010101011.
REQ-016 de transitions SHALL take effect symbol-exact: the first data symbol after a control period is encoded from cnt==0, with no bubble cycle.
REQ-017 cnt arithmetic SHALL use signed extension of the popcount differences; cnt never exceeds the range -16..+15 for legal TMDS operation.

Reset
REQ-018 Asserting rst SHALL immediately, without a clock edge, force cnt=0, the stage-1 de register=0, the stage-1 c register=00, the stage-1 q_m register=0 and q=10'b1101010100 (control token 00). This applies in mid-stream as well.
REQ-019 After rst deasserts, the first 2 output symbols SHALL be control token 00; pipelined inputs then appear per REQ-008.

Configuration
REQ-020 With macro TMDS_ENCODER_OUT_REG_EN defined, a third register SHALL be added after q. Latency becomes 3, and that register resets to 10'b1101010100. Without the macro, latency is 2.

Structure
REQ-021 Package tmds_pkg SHALL hold the four control-token constants, the 10-bit symbol typedef and a popcount8 function.
REQ-022 The block SHALL contain no sub-modules; the serializer and differential buffer are separate downstream modules.

Verification
REQ-023 Scenario: rst pulse mid-stream -> q=0x354 immediately, cnt=0; after release, q stays 0x354 for 2 cycles.
REQ-024 Scenario: de=0 with c=00,01,10,11 on successive cycles -> q=0x354,0x0AB,0x154,0x2AB, 2 cycles later.
REQ-025 Scenario: cnt=0, de=1, d=0x00 twice -> q=0x100 (cnt=-8), then q=0x3FF (cnt=+2).
REQ-026 Scenario: cnt=0, de=1, d=0xFF -> q=0x200, cnt=-8; then de=0, c=00 -> q=0x354, cnt=0.
REQ-027 Scenario: 10,000 random d with random de bursts, compared against a reference model -> every q matches, and cnt is 0 after each control symbol. Also decode each q back to d and verify equality.
REQ-028 Scenario: build with TMDS_ENCODER_OUT_REG_EN defined and rerun REQ-024 -> identical symbols, delayed by 3 cycles.
